// File: rtl/alu_pkg.sv
// Shared ALU decode definitions: control codes, ALUOp and funct7 encodings,
// and the decode/execute slot FSM states.
package alu_pkg;

    localparam int ALUCTRL_W = 5;

    typedef logic [4:0] alu_code_t;

    localparam alu_code_t ALU_ADD    = 5'd0;
    localparam alu_code_t ALU_SUB    = 5'd1;
    localparam alu_code_t ALU_AND    = 5'd2;
    localparam alu_code_t ALU_OR     = 5'd3;
    localparam alu_code_t ALU_XOR    = 5'd4;
    localparam alu_code_t ALU_SLT    = 5'd5;
    localparam alu_code_t ALU_SLL    = 5'd6;
    localparam alu_code_t ALU_SRL    = 5'd7;
    localparam alu_code_t ALU_SGE    = 5'd8;
    localparam alu_code_t ALU_EQ     = 5'd9;
    localparam alu_code_t ALU_NE     = 5'd10;
    localparam alu_code_t ALU_SRA    = 5'd11;
    localparam alu_code_t ALU_SLTU   = 5'd12;
    localparam alu_code_t ALU_SGEU   = 5'd13;
    localparam alu_code_t ALU_MUL    = 5'd16;
    localparam alu_code_t ALU_MULH   = 5'd17;
    localparam alu_code_t ALU_MULHSU = 5'd18;
    localparam alu_code_t ALU_MULHU  = 5'd19;
    localparam alu_code_t ALU_DIV    = 5'd20;
    localparam alu_code_t ALU_DIVU   = 5'd21;
    localparam alu_code_t ALU_REM    = 5'd22;
    localparam alu_code_t ALU_REMU   = 5'd23;

    localparam logic [1:0] ALUOP_MEM = 2'b00;
    localparam logic [1:0] ALUOP_IMM = 2'b01;
    localparam logic [1:0] ALUOP_REG = 2'b10;
    localparam logic [1:0] ALUOP_BR  = 2'b11;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MDU  = 7'b0000001;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_MWAIT
    } state_e;

endpackage

// File: rtl/alu_decode_stage_if.sv
// Upstream/downstream handshake bundle of the ALU decode stage.
// slave = the stage itself, master = whatever drives and consumes it.
interface alu_decode_stage_if #(
    parameter int ALUCTRL_W = alu_pkg::ALUCTRL_W
);
    logic                 valid_in;
    logic                 ready_in;
    logic [1:0]           alu_op;
    logic [2:0]           funct3;
    logic [6:0]           funct7;
    logic                 valid_out;
    logic                 ready_out;
    logic [ALUCTRL_W-1:0] alu_ctrl;
    logic                 is_mdu;
    logic                 illegal;

    modport slave (
        input  valid_in, alu_op, funct3, funct7, ready_out,
        output ready_in, valid_out, alu_ctrl, is_mdu, illegal
    );

    modport master (
        output valid_in, alu_op, funct3, funct7, ready_out,
        input  ready_in, valid_out, alu_ctrl, is_mdu, illegal
    );
endinterface

// File: rtl/alu_ctrl_lut.sv
// Combinational {alu_op, funct3, funct7} -> {alu_ctrl, is_mdu, illegal} decode.
// RV32M encodings decode only when RV32M_EN is defined.
module alu_ctrl_lut #(
    parameter int ALUCTRL_W = alu_pkg::ALUCTRL_W
) (
    input  logic [1:0]           alu_op_i,
    input  logic [2:0]           funct3_i,
    input  logic [6:0]           funct7_i,
    output logic [ALUCTRL_W-1:0] alu_ctrl_o,
    output logic                 is_mdu_o,
    output logic                 illegal_o
);
    import alu_pkg::*;

    alu_code_t code;
    logic      mdu;
    logic      ill;

    always_comb begin
        code = ALU_ADD;
        mdu  = 1'b0;
        ill  = 1'b0;
        unique case (1'b1)
            alu_op_i == ALUOP_MEM: code = ALU_ADD;
            alu_op_i == ALUOP_REG: begin
                if (funct7_i == F7_BASE) begin
                    case (funct3_i)
                        3'b000:  code = ALU_ADD;
                        3'b001:  code = ALU_SLL;
                        3'b010:  code = ALU_SLT;
                        3'b011:  code = ALU_SLTU;
                        3'b100:  code = ALU_XOR;
                        3'b101:  code = ALU_SRL;
                        3'b110:  code = ALU_OR;
                        default: code = ALU_AND;
                    endcase
                end else if (funct7_i == F7_ALT && funct3_i == 3'b000) begin
                    code = ALU_SUB;
                end else if (funct7_i == F7_ALT && funct3_i == 3'b101) begin
                    code = ALU_SRA;
`ifdef RV32M_EN
                end else if (funct7_i == F7_MDU) begin
                    code = ALU_MUL | alu_code_t'(funct3_i);
                    mdu  = 1'b1;
`endif
                end else begin
                    ill = 1'b1;
                end
            end
            alu_op_i == ALUOP_IMM: begin
                case (funct3_i)
                    3'b000: code = ALU_ADD;
                    3'b010: code = ALU_SLT;
                    3'b011: code = ALU_SLTU;
                    3'b100: code = ALU_XOR;
                    3'b110: code = ALU_OR;
                    3'b111: code = ALU_AND;
                    3'b001: begin
                        code = ALU_SLL;
                        ill  = funct7_i != F7_BASE;
                    end
                    default: begin
                        // funct3 101: imm[11:5] selects logical vs arithmetic
                        if (funct7_i == F7_BASE)     code = ALU_SRL;
                        else if (funct7_i == F7_ALT) code = ALU_SRA;
                        else                         ill  = 1'b1;
                    end
                endcase
            end
            alu_op_i == ALUOP_BR: begin
                case (funct3_i)
                    3'b000:  code = ALU_SUB;
                    3'b001:  code = ALU_NE;
                    3'b100:  code = ALU_SLT;
                    3'b101:  code = ALU_SGE;
                    3'b110:  code = ALU_SLTU;
                    3'b111:  code = ALU_SGEU;
                    default: ill  = 1'b1;
                endcase
            end
            default: ill = 1'b1;
        endcase
        if (ill) begin
            code = ALU_ADD;
            mdu  = 1'b0;
        end
    end

    assign alu_ctrl_o = ALUCTRL_W'(code);
    assign is_mdu_o   = mdu;
    assign illegal_o  = ill;

endmodule

// File: rtl/alu_decode_stage.sv
// Registered ALU decode slot with valid/ready handshake and MDU wait modelling.
// Define RV32M_EN to decode RV32M ops and build the MWAIT counter.
module alu_decode_stage #(
    parameter int ALUCTRL_W = alu_pkg::ALUCTRL_W,
    parameter int MUL_LAT   = 2,
    parameter int DIV_LAT   = 8
) (
    input logic               clk,
    input logic               rst_n,
    input logic               flush,
    alu_decode_stage_if.slave bus
);
    import alu_pkg::*;

    if (MUL_LAT < 0 || DIV_LAT < 0) begin : g_bad_lat
        $error("alu_decode_stage: latencies must be non-negative");
    end

    state_e               state_q, state_d;
    logic [ALUCTRL_W-1:0] ctrl_q, ctrl_d;
    logic                 mdu_q, mdu_d;
    logic                 ill_q, ill_d;

    logic [ALUCTRL_W-1:0] lut_ctrl;
    logic                 lut_mdu;
    logic                 lut_ill;
    logic                 ready;
    logic                 accept;

    alu_ctrl_lut #(
        .ALUCTRL_W (ALUCTRL_W)
    ) u_lut (
        .alu_op_i   (bus.alu_op),
        .funct3_i   (bus.funct3),
        .funct7_i   (bus.funct7),
        .alu_ctrl_o (lut_ctrl),
        .is_mdu_o   (lut_mdu),
        .illegal_o  (lut_ill)
    );

`ifdef RV32M_EN
    localparam int MAXL  = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W = $clog2(MAXL + 1);
    localparam int CW    = (CNT_W < 1) ? 1 : CNT_W;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] lat;

    // funct3[2] separates DIV/REM from the MUL family
    assign lat = bus.funct3[2] ? CW'(DIV_LAT) : CW'(MUL_LAT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`endif

    assign ready = !flush &&
                   (state_q == ST_IDLE ||
                    (state_q == ST_HOLD && bus.ready_out));
    assign accept = bus.valid_in && ready;

    always_comb begin
        state_d = state_q;
        ctrl_d  = ctrl_q;
        mdu_d   = mdu_q;
        ill_d   = ill_q;
`ifdef RV32M_EN
        cnt_d   = cnt_q;
`endif
        if (flush) begin
            state_d = ST_IDLE;
`ifdef RV32M_EN
            cnt_d   = '0;
`endif
        end else if (accept) begin
            ctrl_d  = lut_ctrl;
            mdu_d   = lut_mdu;
            ill_d   = lut_ill;
            state_d = ST_HOLD;
`ifdef RV32M_EN
            if (lut_mdu && lat != '0) begin
                state_d = ST_MWAIT;
                cnt_d   = lat;
            end
`endif
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (bus.ready_out) state_d = ST_IDLE;
                end
`ifdef RV32M_EN
                ST_MWAIT: begin
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) state_d = ST_HOLD;
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ctrl_q  <= '0;
            mdu_q   <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            mdu_q   <= mdu_d;
            ill_q   <= ill_d;
        end
    end

    assign bus.ready_in  = ready;
    assign bus.valid_out = state_q == ST_HOLD;
    assign bus.alu_ctrl  = ctrl_q;
    assign bus.is_mdu    = mdu_q;
    assign bus.illegal   = ill_q;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed + random bench for alu_decode_stage against a table/slot model.
// Define RV32M_EN to exercise the MDU wait timing.
module tb_alu_decode_stage;
    import alu_pkg::*;

    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;

    alu_decode_stage_if bus ();

    alu_decode_stage #(
        .ALUCTRL_W (ALUCTRL_W),
        .MUL_LAT   (MUL_LAT),
        .DIV_LAT   (DIV_LAT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Golden decode table indexed by {alu_op, funct3, funct7}
    int ref_code [0:4095];
    bit ref_ill  [0:4095];
    bit ref_mdu  [0:4095];

    // Slot model: full + remaining wait cycles
    bit m_full;
    int m_wait;
    int m_code;
    bit m_mdu;
    bit m_ill;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic legal(int op, int f3, int f7, int code, bit mdu);
        int i;
        i = (op << 10) | (f3 << 7) | f7;
        ref_code[i] = code;
        ref_ill[i]  = 1'b0;
        ref_mdu[i]  = mdu;
    endtask

    task automatic build_table();
        int rc [8];
        int bc [8];
        rc = '{0, 6, 5, 12, 4, 7, 3, 2};
        bc = '{1, 10, -1, -1, 5, 8, 12, 13};
        for (int i = 0; i < 4096; i++) begin
            ref_code[i] = 0;
            ref_ill[i]  = 1'b1;
            ref_mdu[i]  = 1'b0;
        end
        for (int f3 = 0; f3 < 8; f3++)
            for (int f7 = 0; f7 < 128; f7++)
                legal(0, f3, f7, 0, 1'b0);
        for (int f3 = 0; f3 < 8; f3++) begin
            legal(2, f3, 0, rc[f3], 1'b0);
`ifdef RV32M_EN
            legal(2, f3, 1, 16 + f3, 1'b1);
`endif
            if (bc[f3] >= 0) legal(3, f3, 0, bc[f3], 1'b0);
            for (int f7 = 0; f7 < 128; f7++) begin
                if (f3 != 1 && f3 != 5) legal(1, f3, f7, rc[f3], 1'b0);
                if (bc[f3] >= 0) legal(3, f3, f7, bc[f3], 1'b0);
            end
        end
        legal(2, 0, 32, 1, 1'b0);
        legal(2, 5, 32, 11, 1'b0);
        legal(1, 1, 0, 6, 1'b0);
        legal(1, 5, 0, 7, 1'b0);
        legal(1, 5, 32, 11, 1'b0);
    endtask

    task automatic drive(bit v, bit [1:0] op, bit [2:0] f3, bit [6:0] f7,
                         bit ro, bit fl);
        bus.valid_in  = v;
        bus.alu_op    = op;
        bus.funct3    = f3;
        bus.funct7    = f7;
        bus.ready_out = ro;
        flush         = fl;
    endtask

    task automatic model_reset();
        m_full = 1'b0;
        m_wait = 0;
    endtask

    // Check one cycle of outputs against the model, then advance one edge
    task automatic cycle();
        bit v_e;
        bit rdy_e;
        int i;
        #1;
        v_e   = m_full && m_wait == 0;
        rdy_e = !flush && (!m_full || (v_e && bus.ready_out));
        chk("ready_in", bus.ready_in, rdy_e);
        chk("valid_out", bus.valid_out, v_e);
        if (v_e) begin
            chk("alu_ctrl", bus.alu_ctrl, m_code);
            chk("is_mdu", bus.is_mdu, m_mdu);
            chk("illegal", bus.illegal, m_ill);
        end
        @(posedge clk);
        i = {bus.alu_op, bus.funct3, bus.funct7};
        if (flush) begin
            model_reset();
        end else if (bus.valid_in && rdy_e) begin
            m_full = 1'b1;
            m_code = ref_code[i];
            m_mdu  = ref_mdu[i];
            m_ill  = ref_ill[i];
            m_wait = !m_mdu ? 0 : (bus.funct3[2] ? DIV_LAT : MUL_LAT);
        end else if (v_e && bus.ready_out) begin
            m_full = 1'b0;
        end else if (m_full && m_wait > 0) begin
            m_wait--;
        end
        #1;
    endtask

    initial begin
        build_table();
        model_reset();
        rst_n = 1'b0;
        drive(0, ALUOP_MEM, 0, 0, 1, 0);
        #3;
        chk("rst_valid", bus.valid_out, 0);
        chk("rst_ctrl", bus.alu_ctrl, 0);
        chk("rst_ill", bus.illegal, 0);
        chk("rst_mdu", bus.is_mdu, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1 chk("rst_ready", bus.ready_in, 1);

        // SUB then SRA back-to-back
        drive(1, ALUOP_REG, 3'b000, F7_ALT, 1, 0);
        cycle();
        drive(1, ALUOP_REG, 3'b101, F7_ALT, 1, 0);
        chk("sub_valid", bus.valid_out, 1);
        chk("sub_ctrl", bus.alu_ctrl, 1);
        cycle();
        chk("sra_valid", bus.valid_out, 1);
        chk("sra_ctrl", bus.alu_ctrl, 11);

        // XOR held under backpressure with an AND waiting
        drive(1, ALUOP_REG, 3'b100, F7_BASE, 1, 0);
        cycle();
        drive(1, ALUOP_REG, 3'b111, F7_BASE, 0, 0);
        repeat (3) begin
            cycle();
            chk("bp_ctrl", bus.alu_ctrl, 4);
            chk("bp_ready", bus.ready_in, 0);
        end
        drive(1, ALUOP_REG, 3'b111, F7_BASE, 1, 0);
        cycle();
        chk("bp_and", bus.alu_ctrl, 2);

        // Illegal branch, then MUL
        drive(1, ALUOP_BR, 3'b010, F7_BASE, 1, 0);
        cycle();
        chk("br_ill", bus.illegal, 1);
        chk("br_ctrl", bus.alu_ctrl, 0);
        drive(1, ALUOP_REG, 3'b000, F7_MDU, 1, 0);
        cycle();
        drive(0, ALUOP_MEM, 0, 0, 1, 0);
`ifdef RV32M_EN
        chk("mul_wait", bus.valid_out, 0);
        repeat (MUL_LAT) cycle();
        chk("mul_ctrl", bus.alu_ctrl, 16);
        chk("mul_mdu", bus.is_mdu, 1);
`else
        chk("mul_valid", bus.valid_out, 1);
        chk("mul_ill", bus.illegal, 1);
        chk("mul_ctrl", bus.alu_ctrl, 0);
`endif
        cycle();

`ifdef RV32M_EN
        // DIV latency
        drive(1, ALUOP_REG, 3'b100, F7_MDU, 1, 0);
        cycle();
        drive(0, ALUOP_MEM, 0, 0, 1, 0);
        for (int k = 0; k < DIV_LAT; k++) begin
            chk("div_busy", bus.ready_in, 0);
            chk("div_wait", bus.valid_out, 0);
            cycle();
        end
        chk("div_valid", bus.valid_out, 1);
        chk("div_ctrl", bus.alu_ctrl, 20);
        chk("div_mdu", bus.is_mdu, 1);
        cycle();

        // Flush in the third MWAIT cycle
        drive(1, ALUOP_REG, 3'b101, F7_MDU, 1, 0);
        cycle();
        drive(0, ALUOP_MEM, 0, 0, 1, 0);
        cycle();
        cycle();
`else
        // Flush of a held OR
        drive(1, ALUOP_REG, 3'b110, F7_BASE, 0, 0);
        cycle();
`endif
        drive(1, ALUOP_MEM, 0, 0, 1, 1);
        cycle();
        chk("fl_valid", bus.valid_out, 0);
        drive(1, ALUOP_MEM, 0, 0, 1, 0);
        cycle();
        chk("fl_add_v", bus.valid_out, 1);
        chk("fl_add_c", bus.alu_ctrl, 0);

        // Asynchronous reset while an op is pending
`ifdef RV32M_EN
        drive(1, ALUOP_REG, 3'b110, F7_MDU, 1, 0);
        cycle();
        drive(0, ALUOP_MEM, 0, 0, 1, 0);
        cycle();
`else
        drive(1, ALUOP_REG, 3'b100, F7_BASE, 0, 0);
        cycle();
        drive(0, ALUOP_MEM, 0, 0, 0, 0);
`endif
        cycle();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", bus.valid_out, 0);
        chk("arst_ctrl", bus.alu_ctrl, 0);
        chk("arst_ill", bus.illegal, 0);
        chk("arst_mdu", bus.is_mdu, 0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1 chk("arst_ready", bus.ready_in, 1);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            bit [6:0] f7;
            case ($urandom_range(0, 3))
                0:       f7 = F7_BASE;
                1:       f7 = F7_ALT;
                2:       f7 = F7_MDU;
                default: f7 = 7'($urandom);
            endcase
            drive($urandom_range(0, 99) < 70, 2'($urandom), 3'($urandom), f7,
                  $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 4);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
